fifo_rd_stream: RTL
===================

FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

Interface
REQ-001 Parameter DATA_W, default 8, SHALL set the width of the data path in bits.
REQ-002 Parameter CNT_W, default 16, SHALL set the width of the transfer counter (used only under REQ-030).
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rstn  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 i_en  input  1  SHALL enable new FIFO reads when high.
REQ-006 o_fifo_rden  output  1  SHALL be the read enable to the upstream RAM FIFO.
REQ-007 i_fifo_rddata  input  DATA_W  SHALL be the upstream FIFO head word, valid in the same cycle whenever i_fifo_empty is low.
REQ-008 i_fifo_empty  input  1  SHALL be the upstream FIFO empty flag.
REQ-009 o_valid  output  1  SHALL indicate that o_data holds a valid beat.
REQ-010 o_data  output  DATA_W  SHALL be the registered head beat.
REQ-011 i_ready  input  1  SHALL indicate that the consumer accepts the beat; a beat transfers when o_valid and i_ready are both high.
REQ-012 o_level  output  2  SHALL report the buffer occupancy (0, 1 or 2).

Function
REQ-013 The block SHALL hold a 2-entry output buffer (head, skid) controlled by an FSM with states EMPTY (level 0), ONE (level 1) and TWO (level 2).
REQ-014 o_fifo_rden SHALL equal i_en AND NOT i_fifo_empty AND (level < 2), with no combinational path from i_ready.
REQ-015 When o_fifo_rden is high, i_fifo_rddata SHALL be captured at that clock edge: into head if head is empty or being popped in that cycle, otherwise into skid.
REQ-016 A pop (o_valid AND i_ready) SHALL move skid into head when level is 2, otherwise clear head.
REQ-017 FSM transitions: push only -> level+1; pop only -> level-1; push and pop together -> level unchanged; neither -> unchanged.
REQ-018 In TWO, no push SHALL occur; a pop SHALL move the FSM to ONE.
REQ-019 Latency: a word read in cycle N SHALL appear on o_valid/o_data in cycle N+1 when the buffer was empty or being drained.
REQ-020 With i_ready held high and the upstream FIFO non-empty, throughput SHALL be one beat per cycle in steady state (level stays 1).
REQ-021 Beat order SHALL equal upstream FIFO order; no beat SHALL be dropped or duplicated.
REQ-022 o_valid SHALL be high exactly when level > 0; o_data and o_valid SHALL remain stable while o_valid is high and i_ready is low.
REQ-023 When i_en is low, no reads SHALL be issued, and buffered beats SHALL still drain to the consumer.
REQ-024 When i_fifo_empty is high, o_fifo_rden SHALL be low regardless of other inputs.

Reset
REQ-025 Asserting rstn low SHALL immediately force the FSM to EMPTY: o_valid=0, o_data=0, o_level=0, and the skid entry cleared.
REQ-026 During reset, o_fifo_rden SHALL be 0 (gated by reset state), so the upstream FIFO is never read.
REQ-027 Reset asserted mid-operation SHALL discard buffered beats; the first beat after reset release SHALL be the upstream head at that time.
REQ-028 No upstream read SHALL be issued in the first cycle after rstn deassertion.

Configuration
REQ-029 Macro FIFO_RD_STREAM_STAT_EN SHALL select whether the transfer counter is compiled in.
REQ-030 With FIFO_RD_STREAM_STAT_EN defined, output o_xfer_cnt (CNT_W bits) SHALL be present, reset to 0, increment by 1 on each transferred beat, and wrap from 2^CNT_W-1 to 0.
REQ-031 Without FIFO_RD_STREAM_STAT_EN, the o_xfer_cnt port and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-032 Upstream holds 0x11,0x22,0x33; i_en=1; i_ready=1 -> o_valid high in cycles 2-4 with data 0x11,0x22,0x33; o_level=1 throughout.
REQ-033 Upstream holds 4 words; i_ready=0 -> exactly 2 reads, o_level=2, o_data=first word stable; then i_ready=1 -> all 4 beats delivered in order.
REQ-034 Level 1; i_en=0; i_ready=1 -> one beat delivered, o_level=0, o_fifo_rden stays 0.
REQ-035 Level 2; rstn pulsed low asynchronously between clock edges -> o_valid=0 and o_level=0 at once; after release the next beat equals the upstream head.
REQ-036 With FIFO_RD_STREAM_STAT_EN defined and CNT_W=4, 17 beats transferred -> o_xfer_cnt=1.
REQ-037 Random i_ready/i_fifo_empty for 10k cycles against a scoreboard -> zero order, loss or duplication errors; o_fifo_rden never high while i_fifo_empty is high.

Source files
------------

// File: rtl/fifo_rd_stream.sv
// rtl/fifo_rd_stream.sv - two-entry registered read stream in front of a RAM FIFO
//
// Purpose:
//   Reads words from an upstream first-word-fall-through RAM FIFO and presents
//   them as a registered valid/ready stream. A head register and a skid register
//   absorb the one-cycle gap between a consumer stall and the registered read
//   enable. Because of that gap, the read enable never depends on i_ready.
//
// Optional feature:
//   FIFO_RD_STREAM_STAT_EN - when defined, adds o_xfer_cnt, a wrapping count of
//   beats transferred to the consumer.
//
// Ports:
//   clk            clock, rising edge
//   rstn           asynchronous active-low reset
//   i_en           allow new upstream reads
//   o_fifo_rden    upstream FIFO read enable
//   i_fifo_rddata  upstream FIFO head word
//   i_fifo_empty   upstream FIFO empty flag
//   o_valid        o_data holds a beat
//   o_data         head beat
//   i_ready        consumer accepts the beat
//   o_level        buffered beats (0..2)
//   o_xfer_cnt     transferred beat count (FIFO_RD_STREAM_STAT_EN only)

module fifo_rd_stream #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              i_en,
  output logic              o_fifo_rden,
  input  logic [DATA_W-1:0] i_fifo_rddata,
  input  logic              i_fifo_empty,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  input  logic              i_ready,
`ifdef FIFO_RD_STREAM_STAT_EN
  output logic [1:0]        o_level,
  output logic [CNT_W-1:0]  o_xfer_cnt
`else
  output logic [1:0]        o_level
`endif
);

  // State encoding equals the buffer occupancy, so o_level is the state itself.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] head_q, head_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  // Cleared by reset and set on the first edge after release; it holds off
  // reads while in reset and for the first cycle after reset is released.
  logic              armed_q, armed_d;

  logic push;
  logic pop;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_EMPTY;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      armed_q <= armed_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    armed_d = 1'b1;
    case (state_q)
      ST_EMPTY: begin
        if (push) state_d = ST_ONE;
      end
      ST_ONE: begin
        if (push && !pop)      state_d = ST_TWO;
        else if (pop && !push) state_d = ST_EMPTY;
      end
      ST_TWO: begin
        // No read can be issued while both entries are full.
        if (pop) state_d = ST_ONE;
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    o_valid     = (state_q != ST_EMPTY);
    o_level     = state_q;
    o_data      = head_q;
    // Gated only by registered state so a consumer stall has no
    // combinational path into the upstream read enable.
    o_fifo_rden = armed_q && i_en && !i_fifo_empty && (state_q != ST_TWO);
  end

  assign push = o_fifo_rden;
  assign pop  = o_valid && i_ready;

  // ---------------------------------------------------------------------------
  // Head / skid datapath
  // ---------------------------------------------------------------------------
  always_comb begin
    head_d = head_q;
    skid_d = skid_q;
    if (pop) begin
      if (state_q == ST_TWO) begin
        head_d = skid_q;
        skid_d = '0;
      end else begin
        head_d = '0;
      end
    end
    // A pushed word lands in head whenever head is free this cycle; the skid
    // only catches the word read while the head beat is stalled.
    if (push) begin
      if ((state_q == ST_EMPTY) || pop) head_d = i_fifo_rddata;
      else                              skid_d = i_fifo_rddata;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      head_q <= '0;
      skid_q <= '0;
    end else begin
      head_q <= head_d;
      skid_q <= skid_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Transfer counter
  // ---------------------------------------------------------------------------
`ifdef FIFO_RD_STREAM_STAT_EN
  logic [CNT_W-1:0] xfer_cnt_q, xfer_cnt_d;

  always_comb begin
    xfer_cnt_d = xfer_cnt_q;
    if (pop) xfer_cnt_d = xfer_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) xfer_cnt_q <= '0;
    else       xfer_cnt_q <= xfer_cnt_d;
  end

  assign o_xfer_cnt = xfer_cnt_q;
`else
  // Counter width is meaningful only with the counter compiled in.
  logic [CNT_W-1:0] unused_cnt_w;
  assign unused_cnt_w = '0;
`endif

endmodule
